// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - vblank-synchronised sequencer for per-frame game-logic update stages
module frame_update_scheduler #(
    parameter int NUM_STAGES    = 3,
    parameter int DISPLAY_V     = 480,
    parameter int DEADLINE_LINE = 524,
    parameter int FRAME_DIV     = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  p_tick,
    input  logic                  enable,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  overrun_clr,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic                  commit,
    output logic                  busy,
    output logic [2:0]            cur_stage,
    output logic [15:0]           frame_cnt,
    output logic                  overrun
);

    localparam logic [9:0] VB_LINE    = 10'(DISPLAY_V);
    localparam logic [9:0] DL_LINE    = 10'(DEADLINE_LINE);
    localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_COMMIT} state_t;

    state_t     state, next_state;
    logic [7:0] div_cnt;
    logic [7:0] done_pad;
    logic       vb_evt, dl_evt, done_sel, run_go;

    assign vb_evt   = p_tick && (x == 10'd0) && (y == VB_LINE);
    assign dl_evt   = p_tick && (x == 10'd0) && (y == DL_LINE);
    // Widen so a 3-bit stage index always selects a legal bit.
    assign done_pad = 8'(stage_done);
    assign done_sel = done_pad[cur_stage];
    assign run_go   = vb_evt && (div_cnt == DIV_LAST) && enable;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (run_go) next_state = S_START;
            S_START:  next_state = dl_evt ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (dl_evt) begin
                    next_state = S_IDLE;
                end else if (done_sel) begin
                    next_state = (cur_stage == LAST_STAGE) ? S_COMMIT : S_START;
                end
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start[i] = (state == S_START) && (cur_stage == 3'(i));
        end
        commit = (state == S_COMMIT);
        busy   = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cur_stage <= 3'd0;
            div_cnt   <= 8'd0;
            frame_cnt <= 16'd0;
            overrun   <= 1'b0;
        end else begin
            if (vb_evt) frame_cnt <= frame_cnt + 16'd1;
            // A deadline abort below overrides a same-cycle clear.
            if (overrun_clr) overrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vb_evt) begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= 8'd0;
                            if (enable) cur_stage <= 3'd0;
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                S_START, S_WAIT: begin
                    if (dl_evt) begin
                        overrun   <= 1'b1;
                        cur_stage <= 3'd0;
                    end else if (state == S_WAIT && done_sel && cur_stage != LAST_STAGE) begin
                        cur_stage <= cur_stage + 3'd1;
                    end
                end
                S_COMMIT: cur_stage <= 3'd0;
                default:  cur_stage <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb/tb_frame_update_scheduler.sv - directed self-checking bench for frame_update_scheduler
module tb_frame_update_scheduler;

    logic        clk, clr, p_tick, enable, overrun_clr;
    logic [9:0]  x, y;
    logic [2:0]  stage_done;
    logic [2:0]  stage_start, d_start;
    logic        commit, busy, overrun, d_commit, d_busy, d_overrun;
    logic [2:0]  cur_stage, d_cur;
    logic [15:0] frame_cnt, d_frame;

    int n_vec = 0;
    int n_bad = 0;
    int busy_cyc = 0;
    int commit_cyc = 0;

    frame_update_scheduler u_dut (
        .clk(clk), .clr(clr), .x(x), .y(y), .p_tick(p_tick), .enable(enable),
        .stage_done(stage_done), .overrun_clr(overrun_clr),
        .stage_start(stage_start), .commit(commit), .busy(busy),
        .cur_stage(cur_stage), .frame_cnt(frame_cnt), .overrun(overrun)
    );

    frame_update_scheduler #(.FRAME_DIV(3)) u_div (
        .clk(clk), .clr(clr), .x(x), .y(y), .p_tick(p_tick), .enable(enable),
        .stage_done(stage_done), .overrun_clr(overrun_clr),
        .stage_start(d_start), .commit(d_commit), .busy(d_busy),
        .cur_stage(d_cur), .frame_cnt(d_frame), .overrun(d_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (commit) commit_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vb_pulse();
        p_tick = 1'b1; x = 10'd0; y = 10'd480;
        step();
        p_tick = 1'b0; y = 10'd0;
    endtask

    task automatic dl_pulse();
        p_tick = 1'b1; x = 10'd0; y = 10'd524;
        step();
        p_tick = 1'b0; y = 10'd0;
    endtask

    task automatic done_pulse(input int k);
        stage_done = 3'(1 << k);
        step();
        stage_done = 3'b000;
    endtask

    // From START of stage `from`, answer each remaining stage after one WAIT cycle.
    task automatic finish_run(input int from);
        for (int k = from; k < 3; k++) begin
            step();
            done_pulse(k);
        end
        step();
    endtask

    int b0, c0;

    initial begin
        clr = 1'b1; p_tick = 1'b0; x = 10'd5; y = 10'd0; enable = 1'b1;
        stage_done = 3'b000; overrun_clr = 1'b0;
        step(); step();
        clr = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_start", stage_start, 0);
        chk("rst_commit", commit, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_overrun", overrun, 0);

        // Nominal: each stage done 5 cycles after its start.
        repeat (3) step();
        b0 = busy_cyc; c0 = commit_cyc;
        vb_pulse();
        chk("nom_start0", stage_start, 3'b001);
        repeat (5) step();
        done_pulse(0);
        chk("nom_start1", stage_start, 3'b010);
        chk("nom_cur1", cur_stage, 1);
        repeat (5) step();
        done_pulse(1);
        chk("nom_start2", stage_start, 3'b100);
        repeat (5) step();
        done_pulse(2);
        chk("nom_commit", commit, 1);
        chk("nom_start_c", stage_start, 0);
        step();
        chk("nom_idle", busy, 0);
        chk("nom_busy_len", busy_cyc - b0, 19);
        chk("nom_commits", commit_cyc - c0, 1);
        chk("nom_frame", frame_cnt, 1);

        // Reset mid-run in WAIT of stage 1.
        vb_pulse();
        step();
        done_pulse(0);
        step();
        chk("mid_cur", cur_stage, 1);
        clr = 1'b1; step(); step(); clr = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_start", stage_start, 0);
        chk("mid_cur0", cur_stage, 0);
        chk("mid_frame", frame_cnt, 0);
        chk("mid_overrun", overrun, 0);

        // Deadline miss: stage 1 never answers.
        c0 = commit_cyc;
        vb_pulse();
        step();
        done_pulse(0);
        repeat (4) step();
        dl_pulse();
        chk("dl_overrun", overrun, 1);
        chk("dl_busy", busy, 0);
        chk("dl_cur", cur_stage, 0);
        chk("dl_commits", commit_cyc - c0, 0);
        vb_pulse();
        chk("dl_next_start", stage_start, 3'b001);
        finish_run(0);
        chk("dl_next_commits", commit_cyc - c0, 1);
        chk("dl_sticky", overrun, 1);
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("dl_cleared", overrun, 0);

        // Race: last-stage done together with the deadline.
        c0 = commit_cyc;
        vb_pulse();
        step(); done_pulse(0);
        step(); done_pulse(1);
        step();
        stage_done = 3'b100; p_tick = 1'b1; x = 10'd0; y = 10'd524;
        step();
        stage_done = 3'b000; p_tick = 1'b0; y = 10'd0;
        chk("race_overrun", overrun, 1);
        chk("race_busy", busy, 0);
        step();
        chk("race_commits", commit_cyc - c0, 0);

        // Overrun set and clear in the same cycle.
        overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
        chk("clr_pre", overrun, 0);
        vb_pulse();
        p_tick = 1'b1; x = 10'd0; y = 10'd524; overrun_clr = 1'b1;
        step();
        p_tick = 1'b0; y = 10'd0; overrun_clr = 1'b0;
        chk("setclr_overrun", overrun, 1);
        chk("setclr_busy", busy, 0);

        // Done for the wrong stage is ignored.
        vb_pulse();
        step();
        done_pulse(2);
        chk("wrong_cur", cur_stage, 0);
        chk("wrong_busy", busy, 1);
        chk("wrong_start", stage_start, 0);
        step();
        done_pulse(0);
        chk("wrong_then_ok", stage_start, 3'b010);
        finish_run(1);

        // Divider of 3, enable held high: runs on vblanks 3 and 6.
        clr = 1'b1; step(); clr = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            vb_pulse();
            chk($sformatf("div_busy_v%0d", v), d_busy, (v % 3 == 0) ? 1 : 0);
            finish_run(0);
        end
        chk("div_frame", d_frame, 6);

        // Same, but enable low on vblank 3 consumes that slot.
        clr = 1'b1; step(); clr = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            enable = (v == 3) ? 1'b0 : 1'b1;
            vb_pulse();
            chk($sformatf("dive_busy_v%0d", v), d_busy, (v == 6) ? 1 : 0);
            finish_run(0);
        end
        enable = 1'b1;
        chk("dive_frame", d_frame, 6);

        // frame_cnt wraps modulo 2^16.
        clr = 1'b1; step(); clr = 1'b0;
        enable = 1'b0;
        p_tick = 1'b1; x = 10'd0; y = 10'd480;
        repeat (65535) step();
        chk("wrap_max", frame_cnt, 16'hFFFF);
        step();
        p_tick = 1'b0; y = 10'd0;
        chk("wrap_zero", frame_cnt, 0);
        chk("wrap_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
